ps2_keyboard: RTL and testbench

//   PS/2 keyboard receiver, directly upstream of the port I/O block. Deserialises
//   11-bit PS/2 frames from the keyboard pins, checks the frame and absorbs E0/F0 prefixes.

---
 rtl/ps2_keyboard.sv | 231 +++++++++++++++++++++++
 tb/tb_ps2_keyboard.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keyboard.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_keyboard
//  Description : Receive-only PS/2 keyboard front end. Synchronises and
//                deglitches the PS/2 clock, deserialises 11-bit frames,
//                checks start/parity/stop, absorbs E0/F0 prefixes and emits
//                one scancode event per key with a single-cycle kdone strobe.
//  Revision    : 1.0  initial release
// ============================================================================
module ps2_keyboard #(
    parameter int FILTER  = 4,
    parameter int TIMEOUT = 50000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       kdone,
    output logic [7:0] kdata,
    output logic       kbreak,
    output logic       kext,
    output logic       ferr
);

    localparam int c_FILT_W = $clog2(FILTER + 1);
    localparam int c_TO_W   = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    // synchroniser and filter state
    logic                r_clk_s1, r_clk_s2;
    logic                r_dat_s1, r_dat_s2;
    logic                r_filt;
    logic [c_FILT_W-1:0] r_fcnt;

    // frame state
    state_t              r_state, w_next;
    logic [2:0]          r_bcnt;
    logic [7:0]          r_shift;
    logic                r_par;
    logic                r_par_ok;
    logic [c_TO_W-1:0]   r_tcnt;

    // prefix flags and output registers
    logic                r_ext_flag, r_brk_flag;
    logic                r_kdone, r_kbreak, r_kext, r_ferr;
    logic [7:0]          r_kdata;

    // per-cycle decode results
    logic                w_flip;
    logic                w_fall;
    logic                w_frame_ok;
    logic                w_frame_bad;
    logic                w_timeout;

    // Two-flop synchronisers; idle PS/2 lines are high, so reset to 1.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2_data;
            r_dat_s2 <= r_dat_s1;
        end
    end

    // The filtered level flips on the FILTER-th consecutive differing sample.
    assign w_flip = (r_clk_s2 != r_filt) && (r_fcnt == c_FILT_W'(FILTER - 1));
    assign w_fall = w_flip && r_filt;

    // Glitch filter on the synchronised PS/2 clock.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_filt <= 1'b1;
            r_fcnt <= '0;
        end else if (r_clk_s2 == r_filt) begin
            r_fcnt <= '0;
        end else if (w_flip) begin
            r_filt <= ~r_filt;
            r_fcnt <= '0;
        end else begin
            r_fcnt <= r_fcnt + c_FILT_W'(1);
        end
    end

    // Frame FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Frame FSM next state and frame verdicts; an edge always beats the timeout.
    always_comb begin
        w_next      = r_state;
        w_frame_ok  = 1'b0;
        w_frame_bad = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fall) begin
                    if (!r_dat_s2) begin
                        w_next = S_DATA;
                    end else begin
                        w_frame_bad = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (w_fall && (r_bcnt == 3'd7)) begin
                    w_next = S_PARITY;
                end
            end
            S_PARITY: begin
                if (w_fall) begin
                    w_next = S_STOP;
                end
            end
            S_STOP: begin
                if (w_fall) begin
                    w_next = S_IDLE;
                    if (r_dat_s2 && r_par_ok) begin
                        w_frame_ok = 1'b1;
                    end else begin
                        w_frame_bad = 1'b1;
                    end
                end
            end
            default: w_next = S_IDLE;
        endcase
        if ((r_state != S_IDLE) && !w_fall && (r_tcnt == c_TO_W'(TIMEOUT))) begin
            w_next    = S_IDLE;
            w_timeout = 1'b1;
        end
    end

    // Shift register, bit counter and odd-parity tracking, advanced on each edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_bcnt   <= 3'd0;
            r_shift  <= 8'h00;
            r_par    <= 1'b0;
            r_par_ok <= 1'b0;
        end else if (w_fall) begin
            case (r_state)
                S_IDLE: begin
                    r_bcnt <= 3'd0;
                    r_par  <= 1'b0;
                end
                S_DATA: begin
                    r_shift <= {r_dat_s2, r_shift[7:1]};
                    r_par   <= r_par ^ r_dat_s2;
                    r_bcnt  <= r_bcnt + 3'd1;
                end
                S_PARITY: begin
                    r_par_ok <= r_par ^ r_dat_s2;
                end
                default: ;
            endcase
        end
    end

    // Inactivity counter: runs only mid-frame, saturates at TIMEOUT.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_tcnt <= '0;
        end else if ((r_state == S_IDLE) || w_fall) begin
            r_tcnt <= '0;
        end else if (r_tcnt != c_TO_W'(TIMEOUT)) begin
            r_tcnt <= r_tcnt + c_TO_W'(1);
        end
    end

    // Prefix absorption and event outputs. A timed-out frame keeps the prefix
    // flags so a late-resumed key sequence is not misreported; malformed frames clear them.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_kdone    <= 1'b0;
            r_kdata    <= 8'h00;
            r_kbreak   <= 1'b0;
            r_kext     <= 1'b0;
            r_ferr     <= 1'b0;
            r_ext_flag <= 1'b0;
            r_brk_flag <= 1'b0;
        end else begin
            r_kdone <= 1'b0;
            r_ferr  <= 1'b0;
            if (w_frame_ok) begin
                if (r_shift == 8'hE0) begin
                    r_ext_flag <= 1'b1;
                end else if (r_shift == 8'hF0) begin
                    r_brk_flag <= 1'b1;
                end else begin
                    r_kdata    <= r_shift;
                    r_kbreak   <= r_brk_flag;
                    r_kext     <= r_ext_flag;
                    r_kdone    <= 1'b1;
                    r_ext_flag <= 1'b0;
                    r_brk_flag <= 1'b0;
                end
            end
            if (w_frame_bad) begin
                r_ferr     <= 1'b1;
                r_ext_flag <= 1'b0;
                r_brk_flag <= 1'b0;
            end
            if (w_timeout) begin
                r_ferr <= 1'b1;
            end
        end
    end

    assign kdone  = r_kdone;
    assign kdata  = r_kdata;
    assign kbreak = r_kbreak;
    assign kext   = r_kext;
    assign ferr   = r_ferr;

endmodule
`default_nettype wire

// File: tb/tb_ps2_keyboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_keyboard
//  Description : Self-checking bench for ps2_keyboard. Drives PS/2 frames on
//                the pins, records kdone events and ferr pulses, and compares
//                them with a key-event model of the PS/2 set-2 prefix rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ps2_keyboard;

    localparam int FILTER  = 4;
    localparam int TIMEOUT = 1000;
    localparam int HALF    = 20;   // PS/2 clock half period in system clocks

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       kdone;
    logic [7:0] kdata;
    logic       kbreak;
    logic       kext;
    logic       ferr;

    int n_checks = 0;
    int n_pass   = 0;

    // observed events: {kbreak, kext, kdata}
    logic [9:0] got_q[$];
    int         got_ferr = 0;

    // reference model state
    logic [9:0] exp_q[$];
    int         exp_ferr = 0;
    logic       m_ext = 1'b0;
    logic       m_brk = 1'b0;

    ps2_keyboard #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .kdone    (kdone),
        .kdata    (kdata),
        .kbreak   (kbreak),
        .kext     (kext),
        .ferr     (ferr)
    );

    always #5 clock = ~clock;

    // record strobes away from the active edge
    always @(negedge clock) begin
        if (kdone) got_q.push_back({kbreak, kext, kdata});
        if (ferr) got_ferr = got_ferr + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // key-event model: a whole frame either decodes or is an error
    task automatic model_frame(input logic [7:0] b, input logic good);
        if (!good) begin
            exp_ferr = exp_ferr + 1;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            exp_q.push_back({m_brk, m_ext, b});
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic clear_obs();
        got_q.delete();
        exp_q.delete();
        got_ferr = 0;
        exp_ferr = 0;
    endtask

    // drive nbits bits of a frame (bit 0 first); optional 3-clock clock glitch in a high phase
    task automatic drive_bits(input logic [10:0] bits, input int nbits, input int glitch_bit);
        for (int i = 0; i < nbits; i++) begin
            repeat (HALF / 2) @(posedge clock);
            ps2_data = bits[i];
            if (i == glitch_bit) begin
                repeat (3) @(posedge clock);
                ps2_clk = 1'b0;
                repeat (3) @(posedge clock);
                ps2_clk = 1'b1;
                repeat (HALF / 2 - 6) @(posedge clock);
            end else begin
                repeat (HALF / 2) @(posedge clock);
            end
            ps2_clk = 1'b0;
            repeat (HALF) @(posedge clock);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input int glitch_bit);
        logic [10:0] bits;
        logic        p;
        p    = ~(^b) ^ bad_par;
        bits = {1'b1, p, b, 1'b0};
        drive_bits(bits, 11, glitch_bit);
        ps2_data = 1'b1;
        repeat (30) @(posedge clock);
        model_frame(b, !bad_par);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (5) @(posedge clock);
        @(negedge clock);
        n_checks++; if (kdone !== 1'b0) $display("FAIL reset_kdone got %b exp 0", kdone); else n_pass++;
        n_checks++; if (kdata !== 8'h00) $display("FAIL reset_kdata got %h exp 00", kdata); else n_pass++;
        n_checks++; if ({kbreak, kext, ferr} !== 3'b000) $display("FAIL reset_flags got %b exp 000", {kbreak, kext, ferr}); else n_pass++;
        reset_n = 1'b1;
        repeat (10) @(posedge clock);
        clear_obs();
    endtask

    task automatic test_make();
        clear_obs();
        send_frame(8'h1C, 1'b0, -1);
        n_checks++; if (got_q.size() !== 1) $display("FAIL make_count got %0d exp 1", got_q.size()); else n_pass++;
        if (got_q.size() > 0) begin
            n_checks++; if (got_q[0] !== 10'h01C) $display("FAIL make_event got %h exp 01c", got_q[0]); else n_pass++;
        end
        n_checks++; if (got_ferr !== 0) $display("FAIL make_ferr got %0d exp 0", got_ferr); else n_pass++;
        n_checks++; if (kdata !== 8'h1C) $display("FAIL make_hold got %h exp 1c", kdata); else n_pass++;
    endtask

    task automatic test_break();
        clear_obs();
        send_frame(8'hF0, 1'b0, -1);
        send_frame(8'h1C, 1'b0, -1);
        send_frame(8'h1C, 1'b0, -1);
        n_checks++; if (got_q.size() !== 2) $display("FAIL break_count got %0d exp 2", got_q.size()); else n_pass++;
        if (got_q.size() >= 2) begin
            n_checks++; if (got_q[0] !== {2'b10, 8'h1C}) $display("FAIL break_release got %h exp 21c", got_q[0]); else n_pass++;
            n_checks++; if (got_q[1] !== {2'b00, 8'h1C}) $display("FAIL break_make got %h exp 01c", got_q[1]); else n_pass++;
        end
    endtask

    task automatic test_ext_break();
        clear_obs();
        send_frame(8'hE0, 1'b0, -1);
        send_frame(8'hF0, 1'b0, -1);
        send_frame(8'h75, 1'b0, -1);
        n_checks++; if (got_q.size() !== 1) $display("FAIL ext_count got %0d exp 1", got_q.size()); else n_pass++;
        if (got_q.size() > 0) begin
            n_checks++; if (got_q[0] !== {2'b11, 8'h75}) $display("FAIL ext_event got %h exp 375", got_q[0]); else n_pass++;
        end
        // prefixes must not leak into the next key
        send_frame(8'h75, 1'b0, -1);
        n_checks++; if ({kbreak, kext, kdata} !== {2'b00, 8'h75}) $display("FAIL ext_cleared got %h exp 075", {kbreak, kext, kdata}); else n_pass++;
    endtask

    task automatic test_parity_err();
        clear_obs();
        send_frame(8'h1C, 1'b1, -1);
        n_checks++; if (got_ferr !== 1) $display("FAIL par_ferr got %0d exp 1", got_ferr); else n_pass++;
        n_checks++; if (got_q.size() !== 0) $display("FAIL par_nokdone got %0d exp 0", got_q.size()); else n_pass++;
        send_frame(8'h29, 1'b0, -1);
        n_checks++; if (got_q.size() !== 1 || kdata !== 8'h29) $display("FAIL par_recover got %h (n=%0d) exp 29", kdata, got_q.size()); else n_pass++;
    endtask

    task automatic test_timeout();
        logic [10:0] bits;
        clear_obs();
        bits = {3'b111, 8'b1010_1100};   // start 0 then data bits 0,1,1,0
        drive_bits(bits, 5, -1);
        ps2_data = 1'b1;
        repeat (TIMEOUT + 10) @(posedge clock);
        n_checks++; if (got_ferr !== 1) $display("FAIL timeout_ferr got %0d exp 1", got_ferr); else n_pass++;
        n_checks++; if (got_q.size() !== 0) $display("FAIL timeout_nokdone got %0d exp 0", got_q.size()); else n_pass++;
        send_frame(8'h29, 1'b0, -1);
        n_checks++; if (got_q.size() !== 1 || got_q[0] !== 10'h029) $display("FAIL timeout_recover got n=%0d kdata=%h exp 029", got_q.size(), kdata); else n_pass++;
    endtask

    task automatic test_glitch();
        clear_obs();
        send_frame(8'h1C, 1'b0, 4);
        n_checks++; if (got_q.size() !== 1 || got_q[0] !== 10'h01C) $display("FAIL glitch_event got n=%0d kdata=%h exp 01c", got_q.size(), kdata); else n_pass++;
        n_checks++; if (got_ferr !== 0) $display("FAIL glitch_ferr got %0d exp 0", got_ferr); else n_pass++;
    endtask

    task automatic test_reset_midframe();
        logic [10:0] bits;
        clear_obs();
        send_frame(8'hE0, 1'b0, -1);          // pending prefix must be lost on reset
        bits = {3'b111, 8'b0110_1010};
        drive_bits(bits, 6, -1);
        reset_n = 1'b0;
        m_ext = 1'b0;
        m_brk = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        n_checks++; if ({kdone, kbreak, kext, ferr, kdata} !== 12'h000) $display("FAIL midreset_outputs got %h exp 000", {kdone, kbreak, kext, ferr, kdata}); else n_pass++;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        reset_n  = 1'b1;
        repeat (HALF * 2) @(posedge clock);
        got_q.delete();
        got_ferr = 0;
        send_frame(8'h1C, 1'b0, -1);
        n_checks++; if (got_q.size() !== 1 || got_q[0] !== 10'h01C) $display("FAIL midreset_next got n=%0d kext=%b kdata=%h exp 01c", got_q.size(), kext, kdata); else n_pass++;
        n_checks++; if (got_ferr !== 0) $display("FAIL midreset_ferr got %0d exp 0", got_ferr); else n_pass++;
    endtask

    task automatic test_random();
        logic [7:0] b;
        logic       bad;
        int         sel;
        clear_obs();
        m_ext = 1'b0;
        m_brk = 1'b0;
        for (int i = 0; i < 24; i++) begin
            sel = $urandom_range(0, 5);
            b   = (sel == 0) ? 8'hE0 : (sel == 1) ? 8'hF0 : 8'($urandom);
            bad = ($urandom_range(0, 6) == 0);
            send_frame(b, bad, -1);
            repeat ($urandom_range(0, 40)) @(posedge clock);
        end
        n_checks++; if (got_q.size() !== exp_q.size()) $display("FAIL rand_count got %0d exp %0d", got_q.size(), exp_q.size()); else n_pass++;
        n_checks++; if (got_ferr !== exp_ferr) $display("FAIL rand_ferr got %0d exp %0d", got_ferr, exp_ferr); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) $display("FAIL rand_event[%0d] got %h exp %h", i, got_q[i], exp_q[i]); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_make();
        test_break();
        test_ext_break();
        test_parity_err();
        test_timeout();
        test_glitch();
        test_reset_midframe();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
